// File: rtl/io_pkg.sv
// Shared types and default sizing for the board input conditioner.
package io_pkg;

    typedef enum logic {
        DB_STABLE = 1'b0,
        DB_COUNT  = 1'b1
    } db_state_e;

    localparam int unsigned IO_NUM_BTN   = 4;
    localparam int unsigned IO_NUM_SW    = 32;
    localparam int unsigned IO_DB_CYCLES = 500000;
    localparam int unsigned IO_DB_CNT_W  = 20;

endpackage

// File: rtl/io_input_conditioner_if.sv
// Raw board pins in, conditioned levels/pulses/flags out.
// master: board/stimulus side; slave: the conditioner.
interface io_input_conditioner_if
    import io_pkg::*;
#(
    parameter int unsigned NUM_BTN = IO_NUM_BTN,
    parameter int unsigned NUM_SW  = IO_NUM_SW
);

    logic [NUM_BTN-1:0] i_btn_raw;
    logic [NUM_SW-1:0]  i_sw_raw;
    logic [NUM_BTN-1:0] i_evt_clr;
    logic [NUM_BTN-1:0] o_io_btn;
    logic [NUM_SW-1:0]  o_io_sw;
    logic [NUM_BTN-1:0] o_btn_rise;
    logic [NUM_BTN-1:0] o_btn_evt;

    modport master (
        output i_btn_raw, i_sw_raw, i_evt_clr,
        input  o_io_btn, o_io_sw, o_btn_rise, o_btn_evt
    );

    modport slave (
        input  i_btn_raw, i_sw_raw, i_evt_clr,
        output o_io_btn, o_io_sw, o_btn_rise, o_btn_evt
    );

endinterface

// File: rtl/btn_debounce_cell.sv
// One push-button: 2-FF sync, polarity normalisation, counter debounce,
// and a one-cycle pulse on the accepted press.
module btn_debounce_cell
    import io_pkg::*;
#(
    parameter int unsigned DB_CYCLES      = IO_DB_CYCLES,
    parameter int unsigned DB_CNT_W       = IO_DB_CNT_W,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn_raw,
    output logic o_level,
    output logic o_rise
);

    // Raw pin value when the button is not pressed.
    localparam logic                RAW_IDLE = BTN_ACTIVE_LOW;
    localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

    logic                sync1;
    logic                sync2;
    logic                pressed;
    db_state_e           state;
    logic [DB_CNT_W-1:0] cnt;

    // Synchroniser resets to the idle pin level so release after reset is edge-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= RAW_IDLE;
            sync2 <= RAW_IDLE;
        end else begin
            sync1 <= i_btn_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ RAW_IDLE;

    // Debounce FSM: a change must persist DB_CYCLES cycles; any bounce aborts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= DB_STABLE;
            cnt     <= '0;
            o_level <= 1'b0;
            o_rise  <= 1'b0;
        end else begin
            o_rise <= 1'b0;
            case (state)
                DB_STABLE: begin
                    cnt <= '0;
                    if (pressed != o_level) begin
                        state <= DB_COUNT;
                        cnt   <= DB_CNT_W'(1);
                    end
                end
                DB_COUNT: begin
                    if (pressed == o_level) begin
                        state <= DB_STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        o_level <= pressed;
                        o_rise  <= pressed;
                        state   <= DB_STABLE;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DB_STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/io_input_conditioner.sv
// Board input conditioner: debounced buttons, synchronised switches,
// optional sticky press flags (enabled by defining IO_EVT_LATCH_EN).
module io_input_conditioner
    import io_pkg::*;
#(
    parameter int unsigned NUM_BTN        = IO_NUM_BTN,
    parameter int unsigned NUM_SW         = IO_NUM_SW,
    parameter int unsigned DB_CYCLES      = IO_DB_CYCLES,
    parameter int unsigned DB_CNT_W       = IO_DB_CNT_W,
    parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
    input logic             i_clk,
    input logic             i_rst_n,
    io_input_conditioner_if.slave io
);

    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_rise;
    logic [NUM_SW-1:0]  sw_meta;
    logic [NUM_SW-1:0]  sw_sync;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce_cell #(
            .DB_CYCLES     (DB_CYCLES),
            .DB_CNT_W      (DB_CNT_W),
            .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_btn_raw(io.i_btn_raw[g]),
            .o_level  (btn_level[g]),
            .o_rise   (btn_rise[g])
        );
    end

    // Switches: plain 2-FF synchroniser, no debounce.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= io.i_sw_raw;
            sw_sync <= sw_meta;
        end
    end

    assign io.o_io_btn   = btn_level;
    assign io.o_btn_rise = btn_rise;
    assign io.o_io_sw    = sw_sync;

`ifdef IO_EVT_LATCH_EN
    logic [NUM_BTN-1:0] btn_evt;

    // Sticky press flags; a press arriving with a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btn_evt <= '0;
        end else begin
            btn_evt <= (btn_evt & ~io.i_evt_clr) | btn_rise;
        end
    end

    assign io.o_btn_evt = btn_evt;
`else
    logic unused_evt_clr;

    assign unused_evt_clr = ^io.i_evt_clr;
    assign io.o_btn_evt   = '0;
`endif

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner (DB_CYCLES=8, active-low buttons).
// Timed expectations go into a due-cycle-ordered scoreboard and are compared
// on the falling edge of the cycle they fall due.
module tb_io_input_conditioner;

    localparam int unsigned DBC = 8;
    localparam int unsigned LAT = DBC + 2;

    typedef struct {
        string       tag;
        int unsigned due;
        int          sel;   // 0 io_btn, 1 io_sw, 2 btn_rise, 3 btn_evt
        int          bitn;  // -1: whole vector
        logic [31:0] exp;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rise_cnt [4] = '{0, 0, 0, 0};
    logic [3:0]  prev_rise = '0;
    sb_entry_t   sb_q[$];

    io_input_conditioner_if #(.NUM_BTN(4), .NUM_SW(32)) io_bus ();

    io_input_conditioner #(
        .NUM_BTN       (4),
        .NUM_SW        (32),
        .DB_CYCLES     (DBC),
        .DB_CNT_W      (4),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io     (io_bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return {28'b0, io_bus.o_io_btn};
            1:       return io_bus.o_io_sw;
            2:       return {28'b0, io_bus.o_btn_rise};
            default: return {28'b0, io_bus.o_btn_evt};
        endcase
    endfunction

    function automatic void sb_push(input string tag, input int unsigned due, input int sel,
                                    input int bitn, input logic [31:0] exp);
        sb_entry_t e;
        int        idx;
        e.tag = tag; e.due = due; e.sel = sel; e.bitn = bitn; e.exp = exp;
        idx = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].due > due) begin
                idx = i;
                break;
            end
        end
        sb_q.insert(idx, e);
    endfunction

    // Monitor: pulse bookkeeping plus scoreboard comparisons at each falling edge.
    always @(negedge clk) begin
        sb_entry_t   e;
        logic [31:0] obs;
        if (rst_n === 1'b1) begin
            check("rise_not_consecutive", {28'b0, io_bus.o_btn_rise & prev_rise}, 32'h0);
            for (int b = 0; b < 4; b++)
                if (io_bus.o_btn_rise[b]) rise_cnt[b]++;
        end
        prev_rise = io_bus.o_btn_rise;
        while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e   = sb_q.pop_front();
            obs = observe(e.sel);
            if (e.bitn >= 0) check(e.tag, {31'b0, obs[e.bitn]}, e.exp);
            else             check(e.tag, obs, e.exp);
        end
    end

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        int unsigned c;
        int unsigned guard;
        logic        v;

        // Reset state
        rst_n            = 1'b0;
        io_bus.i_btn_raw = 4'hF;
        io_bus.i_sw_raw  = 32'hFFFF_FFFF;
        io_bus.i_evt_clr = 4'h0;
        wait_cycles(3);
        check("reset_io_btn", observe(0), 32'h0);
        check("reset_io_sw",  observe(1), 32'h0);
        check("reset_rise",   observe(2), 32'h0);
        check("reset_evt",    observe(3), 32'h0);

        rst_n = 1'b1;
        c = cyc;
        for (int unsigned i = 1; i <= 20; i++) sb_push("post_reset_no_rise", c + i, 2, -1, 32'h0);
        sb_push("post_reset_sw_d1", c + 1, 1, -1, 32'h0);
        sb_push("post_reset_sw_d2", c + 2, 1, -1, 32'hFFFF_FFFF);
        sb_push("post_reset_io_btn", c + 20, 0, -1, 32'h0);
        wait_cycles(20);

        // Clean press on button 0
        c = cyc;
        io_bus.i_btn_raw[0] = 1'b0;
        sb_push("press0_before",     c + LAT - 1, 0, 0, 32'h0);
        sb_push("press0_level",      c + LAT,     0, 0, 32'h1);
        sb_push("press0_rise_early", c + LAT - 1, 2, 0, 32'h0);
        sb_push("press0_rise",       c + LAT,     2, 0, 32'h1);
        sb_push("press0_rise_end",   c + LAT + 1, 2, 0, 32'h0);
        wait_cycles(30);
        check("press0_rise_count", 32'(rise_cnt[0]), 32'd1);

        // Bouncing button 1
        v = 1'b0;
        for (int k = 0; k < 10; k++) begin
            io_bus.i_btn_raw[1] = v;
            for (int unsigned i = 1; i <= 3; i++) sb_push("bounce1_low", cyc + i, 0, 1, 32'h0);
            wait_cycles(3);
            v = ~v;
        end
        io_bus.i_btn_raw[1] = 1'b0;
        c = cyc;
        for (int unsigned i = 1; i < LAT; i++) sb_push("bounce1_settle", c + i, 0, 1, 32'h0);
        sb_push("bounce1_level", c + LAT, 0, 1, 32'h1);
        sb_push("bounce1_rise",  c + LAT, 2, 1, 32'h1);
        wait_cycles(15);
        check("bounce1_rise_count", 32'(rise_cnt[1]), 32'd1);

        // Release of button 0: level drops, no rise pulse
        c = cyc;
        io_bus.i_btn_raw[0] = 1'b1;
        sb_push("release0_before",  c + LAT - 1, 0, 0, 32'h1);
        sb_push("release0_level",   c + LAT,     0, 0, 32'h0);
        sb_push("release0_no_rise", c + LAT,     2, 0, 32'h0);
        wait_cycles(12);
        check("release0_rise_count", 32'(rise_cnt[0]), 32'd1);

        // Reset in the middle of a count on button 3
        c = cyc;
        io_bus.i_btn_raw[3] = 1'b0;
        sb_push("count3_pending", c + 5, 0, 3, 32'h0);
        wait_cycles(5);
        rst_n = 1'b0;
        #1;
        check("midreset_io_btn", observe(0), 32'h0);
        check("midreset_rise",   observe(2), 32'h0);
        wait_cycles(2);
        rst_n = 1'b1;
        c = cyc;
        sb_push("restart_before", c + LAT - 1, 0, -1, 32'h0);
        sb_push("restart_level",  c + LAT,     0, -1, 32'hA);
        sb_push("simul_rise",     c + LAT,     2, -1, 32'hA);
        sb_push("simul_rise_end", c + LAT + 1, 2, -1, 32'h0);
        wait_cycles(12);
        check("restart3_rise_count", 32'(rise_cnt[3]), 32'd1);
        check("restart1_rise_count", 32'(rise_cnt[1]), 32'd2);

        // Switch synchroniser latency
        c = cyc;
        io_bus.i_sw_raw = 32'hA5A5_0F0F;
        sb_push("sw_a_d1", c + 1, 1, -1, 32'hFFFF_FFFF);
        sb_push("sw_a_d2", c + 2, 1, -1, 32'hA5A5_0F0F);
        wait_cycles(1);
        io_bus.i_sw_raw = 32'h5A5A_F0F0;
        sb_push("sw_b_d1", cyc + 1, 1, -1, 32'hA5A5_0F0F);
        sb_push("sw_b_d2", cyc + 2, 1, -1, 32'h5A5A_F0F0);
        wait_cycles(4);

        // Release everything before the event-flag section
        io_bus.i_btn_raw = 4'hF;
        wait_cycles(12);
        check("all_released", observe(0), 32'h0);

`ifdef IO_EVT_LATCH_EN
        c = cyc;
        io_bus.i_btn_raw[2] = 1'b0;
        sb_push("evt2_before", c + LAT,      3, 2, 32'h0);
        sb_push("evt2_set",    c + LAT + 1,  3, 2, 32'h1);
        sb_push("evt2_held",   c + LAT + 10, 3, 2, 32'h1);
        wait_cycles(21);
        io_bus.i_btn_raw[2] = 1'b1;
        wait_cycles(12);
        check("evt2_held_release", observe(3), 32'h4);
        io_bus.i_btn_raw[2] = 1'b0;
        wait_cycles(LAT);
        check("evt2_second_rise", observe(2), 32'h4);
        io_bus.i_evt_clr[2] = 1'b1;
        wait_cycles(1);
        io_bus.i_evt_clr[2] = 1'b0;
        check("evt2_set_wins", observe(3), 32'h4);
        wait_cycles(3);
        check("evt2_before_clr", observe(3), 32'h4);
        io_bus.i_evt_clr[2] = 1'b1;
        wait_cycles(1);
        io_bus.i_evt_clr[2] = 1'b0;
        check("evt2_cleared", observe(3), 32'h0);
        wait_cycles(2);
`else
        c = cyc;
        io_bus.i_btn_raw[2] = 1'b0;
        for (int unsigned i = 1; i <= 15; i++) sb_push("evt_tied_low", c + i, 3, -1, 32'h0);
        sb_push("evt_off_rise2", c + LAT, 2, 2, 32'h1);
        wait_cycles(LAT);
        io_bus.i_evt_clr = 4'hF;
        wait_cycles(1);
        io_bus.i_evt_clr = 4'h0;
        wait_cycles(6);
`endif

        guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            wait_cycles(1);
            guard++;
        end
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
